irq_entry_seq: RTL and testbench
================================

# irq_entry_seq

Core-side interrupt entry/exit sequencer: the consumer of the Vic request interface (o_VIC_ctrl / o_VIC_iaddr) and the producer of its return-from-interrupt pulse (i_reti). Captures a vectored request, saves {return PC, condition codes} on a nested context stack, flushes the pipeline and redirects fetch to the vector. On a reti instruction it pops the context, restores PC and flags, and notifies Vic. Sits between Vic and the fetch/branch unit of the 3PA core.

## Interface
- PC_W, 32, program-counter / vector width
- CC_W, 4, condition-code width
- NEST_DEPTH, 4, maximum nested ISR levels (power of two, ≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- i_VIC_ctrl  in  1  single-cycle request pulse from Vic
- i_VIC_iaddr  in  PC_W  ISR vector, valid when i_VIC_ctrl=1
- i_PC  in  PC_W  address of oldest unretired instruction (return address)
- i_CCodes  in  CC_W  current condition codes
- i_reti_exec  in  1  single-cycle pulse: core executed reti
- i_stall  in  1  pipeline stalled; no entry may start
- o_redirect  out  1  fetch redirect strobe
- o_redirect_addr  out  PC_W  redirect target
- o_flush  out  1  flush pipeline (entry only)
- o_CCodes  out  CC_W  restored flags
- o_CCodes_we  out  1  flag restore strobe
- o_reti  out  1  to Vic i_reti, one-cycle pulse
- o_depth  out  log2(NEST_DEPTH)+1  current nesting level
- o_err  out  1  one-cycle pulse: reti with depth 0, or stack overflow attempt

## Operation
- pend_v/pend_addr: set by i_VIC_ctrl (vector latched); cleared when ENTER consumes it. Set and clear same cycle → set wins, new vector kept. New request while pending → overwrite (latest wins; Vic already arbitrated priority).
- reti_p: set by i_reti_exec, cleared when EXIT taken or discarded.
- FSM states S_RUN, S_ENTER, S_EXIT; reset → S_RUN.
- S_RUN: reti_p && depth>0 → S_EXIT (reti has priority). Else reti_p && depth==0 → clear reti_p, o_err pulse, stay. Else pend_v && !i_stall && depth<NEST_DEPTH → S_ENTER. pend_v with depth==NEST_DEPTH → held, o_err pulse once per request.
- S_ENTER (1 cycle): push {i_PC, i_CCodes}; o_redirect=1, o_redirect_addr=pend_addr, o_flush=1; depth+1; → S_RUN.
- S_EXIT (1 cycle): pop; o_redirect=1, o_redirect_addr=popped PC; o_CCodes=popped flags, o_CCodes_we=1; o_reti=1; depth−1; → S_RUN.
- Strobe outputs are decoded from registered state; data outputs are 0 when their strobe is 0.

## Timing
- Reset values: all outputs 0, depth 0, stack pointer 0, pend_v=0, reti_p=0, state S_RUN.
- Entry latency: i_VIC_ctrl at cycle t → o_redirect/o_flush at t+2 (i_stall low at t+1, no reti_p).
- Exit latency: i_reti_exec at t → o_redirect/o_reti at t+2.
- i_stall only gates entry start; ENTER and EXIT are never stretched.
- Back-to-back: minimum one S_RUN cycle between consecutive ENTER/EXIT.
- Reset mid-ISR discards the stack and pending request; no o_reti is issued.

## Structure
- Package irq_pkg: state encoding (S_RUN, S_ENTER, S_EXIT), context record width PC_W+CC_W, depth-width function.
- Sub-module irq_ctx_stack: LIFO, NEST_DEPTH×(PC_W+CC_W), push/pop/full/empty, synchronous active-low reset of pointer; pop data available combinationally in the same cycle.

## Test plan
- Single IRQ: i_VIC_ctrl with iaddr=0x0000_0100, i_PC=0x40, CC=1010 → t+2 redirect to 0x100 with flush, depth=1; reti → redirect 0x40, o_CCodes=1010 with we, o_reti pulse, depth=0.
- Nesting to full: 4 requests (0x100..0x400) → depth 4; 5th → held, o_err pulse; 4 retis return PCs in LIFO order; held 5th enters right after the first reti frees a level.
- Stall gating: request while i_stall=1 for 6 cycles → no redirect until the cycle after i_stall drops.
- Simultaneous: reti_p and pend_v both set → EXIT first, then ENTER; request arriving in the ENTER cycle → captured, entered next.
- Spurious reti at depth 0 → o_err pulse, no o_reti, no redirect.
- rst low while depth=2 → next cycle all outputs 0, depth 0; subsequent reti → o_err.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt entry/exit sequencer.
package irq_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_ENTER = 2'd1,
    S_EXIT  = 2'd2
  } irq_state_e;

  // Nesting counter width: must hold 0..n inclusive.
  function automatic int unsigned depth_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // One saved context is {return PC, condition codes}.
  function automatic int unsigned ctx_w(input int unsigned pc_w, input int unsigned cc_w);
    return pc_w + cc_w;
  endfunction

endpackage

// File: rtl/irq_ctx_stack.sv
// LIFO of saved interrupt contexts; top entry is readable combinationally.
module irq_ctx_stack
  import irq_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 36
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = depth_w(Depth);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] top_idx;

  assign full_o  = (ptr_q == PtrW'(Depth));
  assign empty_o = (ptr_q == '0);
  assign top_idx = AddrW'(ptr_q - PtrW'(1));
  assign rdata_o = mem_q[top_idx];

  // Pointer and storage next state; overflowing push / underflowing pop are ignored.
  always_comb begin
    ptr_d = ptr_q;
    mem_d = mem_q;
    if (push_i && !full_o) begin
      mem_d[ptr_q[AddrW-1:0]] = wdata_i;
      ptr_d = ptr_q + PtrW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PtrW'(1);
    end
  end

  // Only the pointer is reset; stale entries are unreachable once it is zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Context storage.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/irq_entry_seq.sv
// Interrupt entry/exit sequencer: takes a vectored request, saves context,
// redirects fetch; on reti restores context and notifies the interrupt controller.
module irq_entry_seq
  import irq_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CC_W       = 4,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_VIC_ctrl,
  input  logic [PC_W-1:0]                     i_VIC_iaddr,
  input  logic [PC_W-1:0]                     i_PC,
  input  logic [CC_W-1:0]                     i_CCodes,
  input  logic                                i_reti_exec,
  input  logic                                i_stall,
  output logic                                o_redirect,
  output logic [PC_W-1:0]                     o_redirect_addr,
  output logic                                o_flush,
  output logic [CC_W-1:0]                     o_CCodes,
  output logic                                o_CCodes_we,
  output logic                                o_reti,
  output logic [depth_w(NEST_DEPTH)-1:0]      o_depth,
  output logic                                o_err
);

  localparam int unsigned DepthW = depth_w(NEST_DEPTH);
  localparam int unsigned CtxW   = ctx_w(PC_W, CC_W);

  irq_state_e        state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic [PC_W-1:0]   pend_addr_q, pend_addr_d;
  logic              reti_p_q, reti_p_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              err_q, err_d;
  // Overflow already reported for the currently held request.
  logic              ovf_seen_q, ovf_seen_d;

  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [CtxW-1:0]   stk_rdata;
  logic [PC_W-1:0]   pop_pc;
  logic [CC_W-1:0]   pop_cc;

  assign stk_push = (state_q == S_ENTER);
  assign stk_pop  = (state_q == S_EXIT);
  assign pop_pc   = stk_rdata[CtxW-1:CC_W];
  assign pop_cc   = stk_rdata[CC_W-1:0];

  irq_ctx_stack #(
    .Depth (NEST_DEPTH),
    .Width (CtxW)
  ) u_stack (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .wdata_i ({i_PC, i_CCodes}),
    .rdata_o (stk_rdata),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a pending reti beats a pending entry; ENTER/EXIT last one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (reti_p_q) begin
          if (!stk_empty) state_d = S_EXIT;
        end else if (pend_v_q && !i_stall && !stk_full) begin
          state_d = S_ENTER;
        end
      end
      S_ENTER, S_EXIT: state_d = S_RUN;
      default:         state_d = S_RUN;
    endcase
  end

  // Pending flags, nesting level and error pulse; new arrivals win over clears.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    reti_p_d    = reti_p_q;
    depth_d     = depth_q;
    err_d       = 1'b0;
    ovf_seen_d  = ovf_seen_q;
    unique case (state_q)
      S_RUN: begin
        if (reti_p_q) begin
          if (stk_empty) begin
            reti_p_d = 1'b0;
            err_d    = 1'b1;
          end
        end else if (pend_v_q && stk_full && !ovf_seen_q) begin
          err_d      = 1'b1;
          ovf_seen_d = 1'b1;
        end
      end
      S_ENTER: begin
        pend_v_d   = 1'b0;
        ovf_seen_d = 1'b0;
        depth_d    = depth_q + DepthW'(1);
      end
      S_EXIT: begin
        reti_p_d = 1'b0;
        depth_d  = depth_q - DepthW'(1);
      end
      default: ;
    endcase
    if (i_VIC_ctrl) begin
      pend_v_d    = 1'b1;
      pend_addr_d = i_VIC_iaddr;
      ovf_seen_d  = 1'b0;
    end
    if (i_reti_exec) reti_p_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      reti_p_q    <= 1'b0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      ovf_seen_q  <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      reti_p_q    <= reti_p_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end

  // Outputs decoded from registered state; data is zero whenever its strobe is low.
  always_comb begin
    o_redirect      = 1'b0;
    o_redirect_addr = '0;
    o_flush         = 1'b0;
    o_CCodes        = '0;
    o_CCodes_we     = 1'b0;
    o_reti          = 1'b0;
    unique case (state_q)
      S_ENTER: begin
        o_redirect      = 1'b1;
        o_redirect_addr = pend_addr_q;
        o_flush         = 1'b1;
      end
      S_EXIT: begin
        o_redirect      = 1'b1;
        o_redirect_addr = pop_pc;
        o_CCodes        = pop_cc;
        o_CCodes_we     = 1'b1;
        o_reti          = 1'b1;
      end
      default: ;
    endcase
    o_depth = depth_q;
    o_err   = err_q;
  end

endmodule

// File: tb/tb_irq_entry_seq.sv
// Directed bench for irq_entry_seq: cycle table plus multi-cycle sequences.
module tb_irq_entry_seq;

  typedef struct packed {
    logic        redirect;
    logic [31:0] addr;
    logic        flush;
    logic [3:0]  cc;
    logic        we;
    logic        reti;
    logic [2:0]  depth;
    logic        err;
  } out_t;

  typedef struct {
    logic        vic;
    logic [31:0] iaddr;
    logic [31:0] pc;
    logic [3:0]  cc;
    logic        reti;
    logic        stall;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_VIC_ctrl = 1'b0;
  logic [31:0] i_VIC_iaddr = '0;
  logic [31:0] i_PC = '0;
  logic [3:0]  i_CCodes = '0;
  logic        i_reti_exec = 1'b0;
  logic        i_stall = 1'b0;
  logic        o_redirect;
  logic [31:0] o_redirect_addr;
  logic        o_flush;
  logic [3:0]  o_CCodes;
  logic        o_CCodes_we;
  logic        o_reti;
  logic [2:0]  o_depth;
  logic        o_err;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];

  irq_entry_seq #(
    .PC_W       (32),
    .CC_W       (4),
    .NEST_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_VIC_ctrl      (i_VIC_ctrl),
    .i_VIC_iaddr     (i_VIC_iaddr),
    .i_PC            (i_PC),
    .i_CCodes        (i_CCodes),
    .i_reti_exec     (i_reti_exec),
    .i_stall         (i_stall),
    .o_redirect      (o_redirect),
    .o_redirect_addr (o_redirect_addr),
    .o_flush         (o_flush),
    .o_CCodes        (o_CCodes),
    .o_CCodes_we     (o_CCodes_we),
    .o_reti          (o_reti),
    .o_depth         (o_depth),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic out_t mk_out(input logic rd, input logic [31:0] a, input logic fl,
                                  input logic [3:0] c, input logic w, input logic r,
                                  input logic [2:0] d, input logic e);
    out_t o;
    o.redirect = rd; o.addr = a; o.flush = fl; o.cc = c;
    o.we = w; o.reti = r; o.depth = d; o.err = e;
    return o;
  endfunction

  function automatic out_t idle(input logic [2:0] d);
    return mk_out(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, d, 1'b0);
  endfunction

  function automatic out_t cur_out();
    return mk_out(o_redirect, o_redirect_addr, o_flush, o_CCodes, o_CCodes_we, o_reti,
                  o_depth, o_err);
  endfunction

  task automatic add(input logic vic, input logic [31:0] ia, input logic [31:0] pc,
                     input logic [3:0] cc, input logic rt, input logic st, input out_t e);
    vec_t v;
    v.vic = vic; v.iaddr = ia; v.pc = pc; v.cc = cc;
    v.reti = rt; v.stall = st; v.exp = e;
    vecs.push_back(v);
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t exp);
    out_t act;
    act = cur_out();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got rd=%b a=%0h fl=%b cc=%0h we=%b rt=%b d=%0d e=%b, expected rd=%b a=%0h fl=%b cc=%0h we=%b rt=%b d=%0d e=%b",
               name, act.redirect, act.addr, act.flush, act.cc, act.we, act.reti, act.depth,
               act.err, exp.redirect, exp.addr, exp.flush, exp.cc, exp.we, exp.reti,
               exp.depth, exp.err);
    end
  endtask

  task automatic do_irq(input logic [31:0] addr, input logic [31:0] pc, input logic [3:0] cc,
                        input logic [2:0] d_before);
    i_PC = pc; i_CCodes = cc;
    i_VIC_ctrl = 1'b1; i_VIC_iaddr = addr;
    step();
    i_VIC_ctrl = 1'b0;
    chk_out("irq_wait", idle(d_before));
    step();
    chk_out("irq_enter", mk_out(1'b1, addr, 1'b1, 4'h0, 1'b0, 1'b0, d_before, 1'b0));
    step();
  endtask

  task automatic do_reti(input logic [31:0] pc, input logic [3:0] cc, input logic [2:0] d_before);
    i_reti_exec = 1'b1;
    step();
    i_reti_exec = 1'b0;
    step();
    chk_out("reti_exit", mk_out(1'b1, pc, 1'b0, cc, 1'b1, 1'b1, d_before, 1'b0));
    step();
  endtask

  initial begin
    // Single IRQ, spurious reti, then stall-gated entry and its return.
    add(1, 32'h100, 32'h40, 4'b1010, 0, 0, idle(0));
    add(0, 0, 32'h40, 4'b1010, 0, 0, idle(0));
    add(0, 0, 32'h40, 4'b1010, 0, 0, mk_out(1, 32'h100, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 0, idle(1));
    add(0, 0, 0, 0, 0, 0, idle(1));
    add(0, 0, 0, 0, 0, 0, mk_out(1, 32'h40, 0, 4'b1010, 1, 1, 1, 0));
    add(0, 0, 0, 0, 1, 0, idle(0));
    add(0, 0, 0, 0, 0, 0, idle(0));
    add(0, 0, 0, 0, 0, 0, mk_out(0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 32'h200, 0, 0, 0, 1, idle(0));
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, idle(0));
    add(0, 0, 32'h80, 4'h5, 0, 0, idle(0));
    add(0, 0, 32'h80, 4'h5, 0, 0, mk_out(1, 32'h200, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 0, idle(1));
    add(0, 0, 0, 0, 0, 0, idle(1));
    add(0, 0, 0, 0, 0, 0, mk_out(1, 32'h80, 0, 4'h5, 1, 1, 1, 0));
    add(0, 0, 0, 0, 0, 0, idle(0));

    // Reset state.
    rst = 1'b0;
    step();
    step();
    chk_out("reset", idle(0));
    rst = 1'b1;
    step();

    foreach (vecs[k]) begin
      chk_out($sformatf("vec%0d", k), vecs[k].exp);
      i_VIC_ctrl  = vecs[k].vic;
      i_VIC_iaddr = vecs[k].iaddr;
      i_PC        = vecs[k].pc;
      i_CCodes    = vecs[k].cc;
      i_reti_exec = vecs[k].reti;
      i_stall     = vecs[k].stall;
      step();
    end
    i_VIC_ctrl = 1'b0; i_reti_exec = 1'b0; i_stall = 1'b0;

    // Nest to full, overflow attempt held, LIFO unwind.
    for (int i = 0; i < 4; i++)
      do_irq(32'h100 * (i + 1), 32'h1000 + 32'h10 * i, 4'(i), 3'(i));
    chk("nest_depth4", 32'(o_depth), 32'd4);
    i_VIC_ctrl = 1'b1; i_VIC_iaddr = 32'h500;
    step();
    i_VIC_ctrl = 1'b0;
    chk("ovf_err_pre", 32'(o_err), 32'd0);
    step();
    chk_out("ovf_err", mk_out(0, 0, 0, 0, 0, 0, 4, 1));
    step();
    chk("ovf_err_once", 32'(o_err), 32'd0);
    step();
    chk_out("ovf_held", idle(4));
    i_PC = 32'h2000; i_CCodes = 4'hF;
    i_reti_exec = 1'b1;
    step();
    i_reti_exec = 1'b0;
    step();
    chk_out("ovf_reti1", mk_out(1, 32'h1030, 0, 4'h3, 1, 1, 4, 0));
    step();
    chk_out("ovf_gap", idle(3));
    step();
    chk_out("ovf_enter", mk_out(1, 32'h500, 1, 0, 0, 0, 3, 0));
    step();
    chk("ovf_depth", 32'(o_depth), 32'd4);
    do_reti(32'h2000, 4'hF, 3'd4);
    do_reti(32'h1020, 4'h2, 3'd3);
    do_reti(32'h1010, 4'h1, 3'd2);
    do_reti(32'h1000, 4'h0, 3'd1);
    chk("unwind_depth0", 32'(o_depth), 32'd0);

    // Simultaneous reti and request: EXIT first, then ENTER; request in ENTER cycle kept.
    do_irq(32'h600, 32'h300, 4'h6, 3'd0);
    i_VIC_ctrl = 1'b1; i_VIC_iaddr = 32'h700;
    i_reti_exec = 1'b1;
    step();
    i_VIC_ctrl = 1'b0; i_reti_exec = 1'b0;
    chk_out("sim_wait", idle(1));
    step();
    chk_out("sim_exit", mk_out(1, 32'h300, 0, 4'h6, 1, 1, 1, 0));
    i_PC = 32'h310; i_CCodes = 4'h7;
    step();
    chk_out("sim_gap", idle(0));
    step();
    chk_out("sim_enter", mk_out(1, 32'h700, 1, 0, 0, 0, 0, 0));
    i_VIC_ctrl = 1'b1; i_VIC_iaddr = 32'h800;
    step();
    i_VIC_ctrl = 1'b0;
    chk_out("late_gap", idle(1));
    step();
    chk_out("late_enter", mk_out(1, 32'h800, 1, 0, 0, 0, 1, 0));
    step();
    chk("late_depth", 32'(o_depth), 32'd2);

    // Reset mid-ISR with a request still pending behind a stall.
    i_stall = 1'b1;
    i_VIC_ctrl = 1'b1; i_VIC_iaddr = 32'h900;
    step();
    i_VIC_ctrl = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1; i_stall = 1'b0;
    chk_out("rst_mid", idle(0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("rst_nopend%0d", i), idle(0));
    end
    i_reti_exec = 1'b1;
    step();
    i_reti_exec = 1'b0;
    step();
    chk_out("rst_reti_err", mk_out(0, 0, 0, 0, 0, 0, 0, 1));
    step();
    chk_out("rst_reti_after", idle(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
